// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core data port and the data memory bus
//   clk_i, rst_ni (sync, active-low)
//   core_req_i/core_we_i/core_size_i/core_addr_i/core_wd_i : access from core
//   core_rd_o (extended load data), core_stall_o, misalign_o
//   mem_req_o/mem_we_o/mem_be_o/mem_addr_o/mem_wd_o : memory request
//   mem_rd_i/mem_ready_i : memory response
//   Optional macro RISCV_LSU_MISALIGN_CHECK_EN: trap misaligned H/W accesses
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [31:0] wd_q;
  logic [29:0] waddr_q;
  logic [31:0] rd_q;
  logic        idle, busy, is_b, is_h, uns, mis, active, we;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [31:0] wd, lane, ext;
  logic [29:0] waddr;
  logic [3:0]  be;
  // In IDLE the access is taken straight from the core; afterwards from the captured copy
  assign idle  = state_q == IDLE;
  assign busy  = state_q == BUSY;
  assign off   = idle ? core_addr_i[1:0]  : off_q;
  assign size  = idle ? core_size_i       : size_q;
  assign we    = idle ? core_we_i         : we_q;
  assign wd    = idle ? core_wd_i         : wd_q;
  assign waddr = idle ? core_addr_i[31:2] : waddr_q;
  // size[1:0]: 00 = B/BU, 01 = H/HU, 1x = W (sizes 3, 6, 7 fold into W)
  assign is_b = size[1:0] == 2'b00;
  assign is_h = size[1:0] == 2'b01;
  assign uns  = size[2] & ~size[1];
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
  logic mis_q;
  assign mis = (is_h & off[0]) | (~is_b & ~is_h & |off);
  assign misalign_o = mis_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) mis_q <= 1'b0;
    else mis_q <= idle & core_req_i & mis;
`else
  assign mis = 1'b0;
  assign misalign_o = 1'b0;
`endif
  assign be   = is_b ? 4'b0001 << off : is_h ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign lane = is_b ? mem_rd_i >> {off, 3'b000} : mem_rd_i >> {off[1], 4'b0000};
  assign ext  = is_b ? {{24{~uns & lane[7]}}, lane[7:0]} :
                is_h ? {{16{~uns & lane[15]}}, lane[15:0]} : mem_rd_i;
  // The memory side is quiet unless a real (aligned) request is in flight
  assign active       = rst_ni & (idle ? core_req_i & ~mis : busy);
  assign core_stall_o = rst_ni & (idle ? core_req_i : busy);
  assign mem_req_o    = active;
  assign mem_we_o     = active & we;
  assign mem_be_o     = active ? be : 4'b0000;
  assign mem_addr_o   = active ? {waddr, 2'b00} : 32'h0;
  assign mem_wd_o     = active ? (is_b ? {4{wd[7:0]}} : is_h ? {2{wd[15:0]}} : wd) : 32'h0;
  assign core_rd_o    = rd_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      waddr_q <= '0;
      rd_q    <= '0;
    end else begin
      if (active & mem_ready_i & ~we) rd_q <= ext;
      if (idle & core_req_i) begin
        off_q   <= core_addr_i[1:0];
        size_q  <= core_size_i;
        we_q    <= core_we_i;
        wd_q    <= core_wd_i;
        waddr_q <= core_addr_i[31:2];
      end
      state_q <= idle ? (core_req_i ? ((mem_ready_i | mis) ? DONE : BUSY) : IDLE) :
                 busy ? (mem_ready_i ? DONE : BUSY) : IDLE;
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed self-checking bench for riscv_lsu
module tb_riscv_lsu;
  logic        clk_i = 1'b0;
  logic        rst_ni, core_req_i, core_we_i, mem_ready_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, mem_rd_i;
  logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
  logic        core_stall_o, misalign_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  int checks = 0;
  int errors = 0;
  riscv_lsu dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_size_i(core_size_i), .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .misalign_o(misalign_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk_i);
    #2;
  endtask
  task automatic req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic rdy);
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = a;
    core_wd_i = wd; mem_rd_i = rd; mem_ready_i = rdy;
  endtask
  task automatic quiet;
    core_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask
  initial begin
    rst_ni = 1'b0;
    req(1'b1, 3'd2, 32'h104, 32'hFFFF_FFFF, 32'h0, 1'b1);
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wd", mem_wd_o, 0);
    chk("rst_stall", core_stall_o, 0);
    chk("rst_rd", core_rd_o, 0);
    chk("rst_mis", misalign_o, 0);
    cyc; rst_ni = 1'b1; quiet; #1;
    chk("idle_stall", core_stall_o, 0);
    chk("idle_req", mem_req_o, 0);
    // SB with one wait cycle
    cyc; req(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 1'b0); #1;
    chk("sb_be", mem_be_o, 4'b1000);
    chk("sb_wd", mem_wd_o, 32'hA5A5_A5A5);
    chk("sb_addr", mem_addr_o, 32'h100);
    chk("sb_req", mem_req_o, 1);
    chk("sb_we", mem_we_o, 1);
    chk("sb_stall0", core_stall_o, 1);
    cyc; core_addr_i = 32'hFFF; core_wd_i = 32'h0; mem_ready_i = 1'b1; #1;
    chk("sb_busy_addr", mem_addr_o, 32'h100);
    chk("sb_busy_wd", mem_wd_o, 32'hA5A5_A5A5);
    chk("sb_busy_be", mem_be_o, 4'b1000);
    chk("sb_stall1", core_stall_o, 1);
    cyc; quiet; #1;
    chk("sb_done_stall", core_stall_o, 0);
    chk("sb_done_req", mem_req_o, 0);
    // LH, ready in the IDLE cycle
    cyc; req(1'b0, 3'd1, 32'h22, 32'h0, 32'h8001_1234, 1'b1); #1;
    chk("lh_stall", core_stall_o, 1);
    chk("lh_be", mem_be_o, 4'b1100);
    chk("lh_we", mem_we_o, 0);
    chk("lh_addr", mem_addr_o, 32'h20);
    cyc; quiet; mem_rd_i = 32'h0; #1;
    chk("lh_rd", core_rd_o, 32'hFFFF_8001);
    chk("lh_done_stall", core_stall_o, 0);
    cyc; #1;
    chk("lh_hold", core_rd_o, 32'hFFFF_8001);
    // LBU
    cyc; req(1'b0, 3'd4, 32'h41, 32'h0, 32'h0000_F200, 1'b1); #1;
    chk("lbu_be", mem_be_o, 4'b0010);
    cyc; quiet; #1;
    chk("lbu_rd", core_rd_o, 32'h0000_00F2);
    // LB sign extension from lane 3
    cyc; cyc; req(1'b0, 3'd0, 32'h3, 32'h0, 32'h8012_3456, 1'b1);
    cyc; quiet; #1;
    chk("lb_rd", core_rd_o, 32'hFFFF_FF80);
    // LHU upper half
    cyc; cyc; req(1'b0, 3'd5, 32'h2, 32'h0, 32'h8001_1234, 1'b1);
    cyc; quiet; #1;
    chk("lhu_rd", core_rd_o, 32'h0000_8001);
    // SH: stores never update core_rd_o
    cyc; cyc; req(1'b1, 3'd1, 32'h2, 32'h1234_ABCD, 32'hDEAD_BEEF, 1'b1); #1;
    chk("sh_be", mem_be_o, 4'b1100);
    chk("sh_wd", mem_wd_o, 32'hABCD_ABCD);
    chk("sh_addr", mem_addr_o, 32'h0);
    cyc; quiet; #1;
    chk("sh_rd_keep", core_rd_o, 32'h0000_8001);
    // SW
    cyc; cyc; req(1'b1, 3'd2, 32'h8, 32'h1234_ABCD, 32'h0, 1'b1); #1;
    chk("sw_be", mem_be_o, 4'b1111);
    chk("sw_wd", mem_wd_o, 32'h1234_ABCD);
    chk("sw_addr", mem_addr_o, 32'h8);
    cyc; quiet; #1;
    // LW with ready delayed five cycles
    cyc; req(1'b0, 3'd2, 32'h80, 32'h0, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc;
      mem_ready_i = (i == 5);
      #1;
      chk("lat_req", mem_req_o, 1);
      chk("lat_addr", mem_addr_o, 32'h80);
      chk("lat_stall", core_stall_o, 1);
    end
    cyc; quiet; #1;
    chk("lat_done_stall", core_stall_o, 0);
    chk("lat_rd", core_rd_o, 32'h1234_5678);
    cyc; #1;
`ifndef RISCV_LSU_MISALIGN_CHECK_EN
    // Low address bits are ignored for W when no check is built in
    cyc; req(1'b0, 3'd2, 32'h7, 32'h0, 32'hCAFE_F00D, 1'b1); #1;
    chk("lw7_addr", mem_addr_o, 32'h4);
    chk("lw7_be", mem_be_o, 4'b1111);
    chk("lw7_req", mem_req_o, 1);
    cyc; quiet; #1;
    chk("lw7_rd", core_rd_o, 32'hCAFE_F00D);
    chk("lw7_mis", misalign_o, 0);
    cyc; #1;
`endif
    // Reset while BUSY, then a late ready
    cyc; req(1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b0);
    cyc; #1;
    chk("rb_busy_stall", core_stall_o, 1);
    cyc; rst_ni = 1'b0; #1;
    chk("rb_req", mem_req_o, 0);
    chk("rb_stall", core_stall_o, 0);
    chk("rb_addr", mem_addr_o, 0);
    cyc; rst_ni = 1'b1; core_req_i = 1'b0; mem_ready_i = 1'b1; mem_rd_i = 32'hDEAD_BEEF; #1;
    chk("rb_after_stall", core_stall_o, 0);
    chk("rb_after_req", mem_req_o, 0);
    chk("rb_after_rd", core_rd_o, 0);
    cyc; mem_ready_i = 1'b0; #1;
    chk("rb_nocap", core_rd_o, 0);
    chk("rb_idle_stall", core_stall_o, 0);
`ifdef RISCV_LSU_MISALIGN_CHECK_EN
    // Misaligned SW
    cyc; req(1'b1, 3'd2, 32'h6, 32'h1111_2222, 32'h0, 1'b0); #1;
    chk("mis_req", mem_req_o, 0);
    chk("mis_stall", core_stall_o, 1);
    chk("mis_pulse0", misalign_o, 0);
    cyc; quiet; #1;
    chk("mis_pulse", misalign_o, 1);
    chk("mis_done_stall", core_stall_o, 0);
    chk("mis_done_req", mem_req_o, 0);
    chk("mis_rd", core_rd_o, 0);
    cyc; #1;
    chk("mis_clear", misalign_o, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
